// File: rtl/led_pio_blink_pkg.sv
// led_pio_pkg: register addresses, PWM constants and the decoded write-select struct for led_pio_blink.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Ports: none. Optional PWM dimming is selected by the LED_PWM_EN macro in the consuming RTL.
package led_pio_pkg;

   localparam logic [2:0] ADDR_DATA = 3'd0;
   localparam logic [2:0] ADDR_SET  = 3'd1;
   localparam logic [2:0] ADDR_CLR  = 3'd2;
   localparam logic [2:0] ADDR_MASK = 3'd3;
   localparam logic [2:0] ADDR_DIV  = 3'd4;
   localparam logic [2:0] ADDR_STAT = 3'd5;
   localparam logic [2:0] ADDR_DUTY = 3'd6;

   localparam int            PWM_W     = 8;
   localparam logic [PWM_W-1:0] DUTY_FULL = 8'hFF;

   // One-hot-ish decode of a bus write; at most one field is set per cycle.
   typedef struct packed {
      logic data;
      logic set;
      logic clr;
      logic mask;
      logic div;
      logic duty;
   } wr_sel_t;

endpackage

// File: rtl/led_pio_blink_if.sv
// led_pio_blink_if: Avalon-MM slave bus bundle (word address, select, write strobe, data) for the LED PIO.
// Latency: wires only; readdata is combinational on address inside the slave.
// Backpressure: none; the slave has no wait states, every access completes in one cycle.
// Signals: address[2:0], chipselect, write_n (active low), writedata[31:0], readdata[31:0].
interface led_pio_blink_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

endinterface

// File: rtl/led_blink_prescaler.sv
// led_blink_prescaler: counts 0..div and toggles the blink phase at each terminal count.
// Latency: phase changes on the edge where cnt==div; restart clears cnt/phase on the same edge.
// Backpressure: none; free-running, restart always wins over a coincident terminal count.
// Ports: clk, reset_n (async active-low), div[DIV_W-1:0], restart, phase.
module led_blink_prescaler #(
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [DIV_W-1:0] div,
   input  logic             restart,
   output logic             phase
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (restart) begin
         // A new divisor always starts a fresh half-period from phase 0, so cnt
         // can never be left above the new terminal value.
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q == div) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/led_pio_blink.sv
// led_pio_blink: Avalon-MM output PIO for WIDTH LEDs with SET/CLR strobes, per-bit blink mask and optional PWM dimming.
// Latency: register write at edge N reaches out_port at edge N+1; readdata is combinational on address.
// Backpressure: none; zero wait states, writes accepted every cycle, reads have no side effects.
// Ports: clk, reset_n (async active-low), s1 (led_pio_blink_if.slave), out_port[WIDTH-1:0] (registered).
// Optional feature: define LED_PWM_EN to add the DUTY register and global 8-bit PWM dimming.
module led_pio_blink
   import led_pio_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               DIV_W       = 24,
   parameter logic [DIV_W-1:0] DIV_RESET   = DIV_W'(12_499_999)
) (
   input  logic             clk,
   input  logic             reset_n,
   led_pio_blink_if.slave   s1,
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [DIV_W-1:0] div_q,  div_d;
   logic [WIDTH-1:0] out_q,  out_d;

   wr_sel_t          wr_sel;
   logic [WIDTH-1:0] wdata_w;
   logic [DIV_W-1:0] wdata_div;
   logic             phase;
   logic             pwm_on;
   logic [WIDTH-1:0] lit;
   logic [31:0]      rdata;

   assign wdata_w   = s1.writedata[WIDTH-1:0];
   assign wdata_div = s1.writedata[DIV_W-1:0];

   // Write decode: STAT and the reserved address fall through with no select.
   always_comb begin
      wr_sel = '0;
      if (s1.chipselect && !s1.write_n) begin
         case (s1.address)
            ADDR_DATA: wr_sel.data = 1'b1;
            ADDR_SET:  wr_sel.set  = 1'b1;
            ADDR_CLR:  wr_sel.clr  = 1'b1;
            ADDR_MASK: wr_sel.mask = 1'b1;
            ADDR_DIV:  wr_sel.div  = 1'b1;
            ADDR_DUTY: wr_sel.duty = 1'b1;
            default:   wr_sel      = '0;
         endcase
      end
   end

   always_comb begin
      data_d = data_q;
      mask_d = mask_q;
      div_d  = div_q;
      if (wr_sel.data) data_d = wdata_w;
      if (wr_sel.set)  data_d = data_q | wdata_w;
      if (wr_sel.clr)  data_d = data_q & ~wdata_w;
      if (wr_sel.mask) mask_d = wdata_w;
      if (wr_sel.div)  div_d  = wdata_div;
   end

   led_blink_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .div     (div_q),
      .restart (wr_sel.div),
      .phase   (phase)
   );

`ifdef LED_PWM_EN
   logic [PWM_W-1:0] duty_q,    duty_d;
   logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;

   always_comb begin
      duty_d    = duty_q;
      // 8-bit counter wraps 255->0 on its own; DUTY writes never restart the period.
      pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
      if (wr_sel.duty) duty_d = s1.writedata[PWM_W-1:0];
   end

   // Full-scale duty is special-cased so 8'hFF means always on rather than 255/256.
   assign pwm_on = (duty_q == DUTY_FULL) || (pwm_cnt_q < duty_q);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         duty_q    <= DUTY_FULL;
         pwm_cnt_q <= '0;
      end else begin
         duty_q    <= duty_d;
         pwm_cnt_q <= pwm_cnt_d;
      end
   end
`else
   assign pwm_on = 1'b1;
`endif

   // Masked bits follow the blink phase; unmasked bits show DATA steadily.
   always_comb begin
      lit   = data_q & (~mask_q | {WIDTH{phase}});
      out_d = lit & {WIDTH{pwm_on}};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= RESET_VALUE;
         mask_q <= '0;
         div_q  <= DIV_RESET;
         out_q  <= RESET_VALUE;
      end else begin
         data_q <= data_d;
         mask_q <= mask_d;
         div_q  <= div_d;
         out_q  <= out_d;
      end
   end

   assign out_port = out_q;

   // Read mux ignores chipselect; SET and CLR read back DATA.
   always_comb begin
      rdata = '0;
      case (s1.address)
         ADDR_DATA, ADDR_SET, ADDR_CLR: rdata[WIDTH-1:0] = data_q;
         ADDR_MASK:                     rdata[WIDTH-1:0] = mask_q;
         ADDR_DIV:                      rdata[DIV_W-1:0] = div_q;
         ADDR_STAT:                     rdata[0]         = phase;
`ifdef LED_PWM_EN
         ADDR_DUTY:                     rdata[PWM_W-1:0] = duty_q;
`endif
         default:                       rdata            = '0;
      endcase
   end

   assign s1.readdata = rdata;

endmodule
